// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 encryption engine.
//   aes_state_e : control FSM encoding (idle, full round, final round, output hold)
//   RCON        : round constants indexed directly by the 4-bit round counter
//   SBOX        : forward S-box used by sub_bytes and the key schedule
//   BLOCK_W/KEY_W : data-path widths
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KEY_W   = 128;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal,
        StDone
    } aes_state_e;

    // Entry 0 and 11..15 are never selected while a round key is being produced.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: XORs the round key into the state.
//   state_in  : 128-bit state
//   round_key : 128-bit round key
//   state_out : keyed state
module add_round_key
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [KEY_W-1:0]   round_key,
    output logic [BLOCK_W-1:0] state_out
);

    assign state_out = state_in ^ round_key;

endmodule

// File: rtl/aes_final_round.sv
// Final AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
//   state_in  : state entering the last round
//   round_key : last round key
//   state_out : ciphertext
module aes_final_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [KEY_W-1:0]   round_key,
    output logic [BLOCK_W-1:0] state_out
);

    logic [BLOCK_W-1:0] sb_out;
    logic [BLOCK_W-1:0] sr_out;

    sub_bytes u_sub_bytes (
        .state_in  (state_in),
        .state_out (sb_out)
    );

    shift_rows u_shift_rows (
        .state_in  (sb_out),
        .state_out (sr_out)
    );

    add_round_key u_add_round_key (
        .state_in  (sr_out),
        .round_key (round_key),
        .state_out (state_out)
    );

endmodule

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one (RotWord, SubWord, Rcon XOR, then word chaining).
//   key_in  : current round key, word 0 in bits [127:96]
//   rcon    : round constant for the key being produced
//   key_out : next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    assign t = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// MixColumns: multiplies each state column by the fixed GF(2^8) matrix
// [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
//   state_in  : 128-bit state
//   state_out : mixed state
module mix_columns
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    output logic [BLOCK_W-1:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_in[127-32*c -: 8];
        assign a1 = state_in[119-32*c -: 8];
        assign a2 = state_in[111-32*c -: 8];
        assign a3 = state_in[103-32*c -: 8];
        assign state_out[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_out[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_out[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_out[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state is rotated left by r bytes.
// Byte 0 sits in bits [127:120]; byte index = row + 4*column.
//   state_in  : 128-bit state
//   state_out : shifted state
module shift_rows
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    output logic [BLOCK_W-1:0] state_out
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_out[127-8*(r+4*c) -: 8] =
                state_in[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: applies the AES S-box to every byte of the state.
//   state_in  : 128-bit state
//   state_out : substituted state
module sub_bytes
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    output logic [BLOCK_W-1:0] state_out
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign state_out[8*i +: 8] = SBOX[state_in[8*i +: 8]];
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption engine, one round per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : plaintext/key handshake (in_ready only while idle)
//   in_pt, in_key       : plaintext and cipher key, byte 0 in bits [127:120]
//   out_valid/out_ready : ciphertext handshake; out_ct held until accepted
//   out_ct              : ciphertext
// Optional build macro AES_DBG_EN adds dbg_round (current round, 0 when idle
// or holding output) and dbg_rk (round key applied this cycle, 0 otherwise).
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_pt,
    input  logic [KEY_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_ct
`ifdef AES_DBG_EN
    ,
    output logic [3:0]         dbg_round,
    output logic [KEY_W-1:0]   dbg_rk
`endif
);

    if (NR != 10) begin : g_nr_check
        $error("aes_encrypt_iter supports only NR = 10 (AES-128)");
    end

    aes_state_e         fsm_q, fsm_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [3:0]         rnd_q, rnd_d;
    logic               out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0] out_ct_q, out_ct_d;

    logic [KEY_W-1:0]   rk;
    logic [BLOCK_W-1:0] sb_out, sr_out, mc_out, round_out, final_out;

    // Round key for the round currently in flight, produced from the previous one.
    aes_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (RCON[rnd_q]),
        .key_out (rk)
    );

    sub_bytes u_sub_bytes (
        .state_in  (state_q),
        .state_out (sb_out)
    );

    shift_rows u_shift_rows (
        .state_in  (sb_out),
        .state_out (sr_out)
    );

    mix_columns u_mix_columns (
        .state_in  (sr_out),
        .state_out (mc_out)
    );

    add_round_key u_add_round_key (
        .state_in  (mc_out),
        .round_key (rk),
        .state_out (round_out)
    );

    aes_final_round u_final_round (
        .state_in  (state_q),
        .round_key (rk),
        .state_out (final_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            out_ct_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            out_ct_q    <= out_ct_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        out_ct_d    = out_ct_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_pt ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                state_d = round_out;
                key_d   = rk;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'(NR - 1)) begin
                    fsm_d = StFinal;
                end
            end
            StFinal: begin
                out_ct_d    = final_out;
                out_valid_d = 1'b1;
                rnd_d       = '0;
                fsm_d       = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_ct    = out_ct_q;

`ifdef AES_DBG_EN
    logic key_active;
    assign key_active = (fsm_q == StRound) || (fsm_q == StFinal);
    assign dbg_round  = key_active ? rnd_q : '0;
    assign dbg_rk     = key_active ? rk : '0;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, backpressure,
// back-to-back, mid-run reset and random blocks against a byte-level model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_encrypt_iter;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_pt, in_key, out_ct;
`ifdef AES_DBG_EN
    logic [3:0]   dbg_round;
    logic [127:0] dbg_rk;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0]   sb_ref [256];
    logic [127:0] dbg_rk10;
    logic         dbg_seq_ok;

    aes_encrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pt     (in_pt),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct)
`ifdef AES_DBG_EN
        ,
        .dbg_round (dbg_round),
        .dbg_rk    (dbg_rk)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] r, acc;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r = inv;
            acc = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                acc = acc ^ r;
            end
            sb_ref[x] = acc ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [16];
        logic [7:0] g [4];
        logic [7:0] rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            g[0] = sb_ref[w[13]] ^ rc;
            g[1] = sb_ref[w[14]];
            g[2] = sb_ref[w[15]];
            g[3] = sb_ref[w[12]];
            for (int i = 0; i < 4; i++) w[i] = w[i] ^ g[i];
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[i] = sb_ref[s[i]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    t[row+4*col] = s[row+4*((col+row)%4)];
            s = t;
            if (rnd < 10) begin
                for (int col = 0; col < 4; col++)
                    for (int k = 0; k < 4; k++)
                        t[4*col+k] = gmul(s[4*col+k], 8'h02) ^ gmul(s[4*col+(k+1)%4], 8'h03)
                                   ^ s[4*col+(k+2)%4] ^ s[4*col+(k+3)%4];
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] pt, input logic [127:0] key);
        int n = 0;
        in_pt = pt;
        in_key = key;
        in_valid = 1'b1;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("accept_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready", 128'(in_ready), 128'(0));
    endtask

    // Called right after the accept edge; out_valid should rise after 10 edges.
    task automatic wait_out(input string tag, input logic [127:0] exp);
        int lat = 0;
        dbg_seq_ok = 1'b1;
        dbg_rk10 = '0;
        while (!out_valid && lat < 20) begin
`ifdef AES_DBG_EN
            if (dbg_round !== 4'(lat + 1)) dbg_seq_ok = 1'b0;
            if (dbg_round == 4'd10) dbg_rk10 = dbg_rk;
`endif
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(10));
        chk({tag, "_ct"}, out_ct, exp);
`ifdef AES_DBG_EN
        chk({tag, "_dbg_seq"}, 128'(dbg_seq_ok), 128'(1));
        chk({tag, "_dbg_round_done"}, 128'(dbg_round), 128'(0));
`endif
    endtask

    task automatic release_out(input int hold, input logic [127:0] exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_ct", out_ct, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 128'(out_valid), 128'(0));
        chk("release_in_ready", 128'(in_ready), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] outs [2];
        int           acc_cyc [2];
        int           nacc, nout;
        logic         pulsed;
        logic [127:0] rpt, rkey, rexp;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_pt = '0;
        in_key = '0;
        build_sbox();
        #12;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_ct", out_ct, 128'(0));
        #10 rst_n = 1'b1;

        // FIPS-197 Appendix B
        accept(B_PT, B_KEY);
        wait_out("vec_b", B_CT);
`ifdef AES_DBG_EN
        chk("vec_b_dbg_rk10", dbg_rk10, B_RK10);
`endif
        release_out(0, B_CT);

        // FIPS-197 Appendix C.1
        accept(C_PT, C_KEY);
        wait_out("vec_c1", C_CT);
        release_out(0, C_CT);

        // Backpressure with a pending second request
        accept(B_PT, B_KEY);
        wait_out("bp_first", B_CT);
        in_pt = C_PT;
        in_key = C_KEY;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_ct_stable", out_ct, B_CT);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_released_valid", 128'(out_valid), 128'(0));
        chk("bp_released_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_second_taken", 128'(in_ready), 128'(0));
        wait_out("bp_second", C_CT);
        release_out(1, C_CT);

        // Back-to-back with in_valid and out_ready held high
        nacc = 0;
        nout = 0;
        outs[0] = '0;
        outs[1] = '0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        in_pt = B_PT;
        in_key = B_KEY;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && nout < 2; k++) begin
            logic hs;
            hs = in_valid && in_ready;
            if (hs) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (out_valid) begin
                outs[nout] = out_ct;
                nout++;
            end
            tick();
            if (hs) begin
                if (nacc == 1) begin
                    in_pt = C_PT;
                    in_key = C_KEY;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", 128'(nout), 128'(2));
        chk("b2b_ct_b", outs[0], B_CT);
        chk("b2b_ct_c1", outs[1], C_CT);
        chk("b2b_accept_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
        tick();

        // Reset during round 5 aborts the block
        accept(B_PT, B_KEY);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_ct", out_ct, 128'(0));
        tick();
        tick();
        #2 rst_n = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) pulsed = 1'b1;
        end
        chk("midrst_no_pulse", 128'(pulsed), 128'(0));
        accept(C_PT, C_KEY);
        wait_out("midrst_c1", C_CT);
        release_out(0, C_CT);

        // Random blocks against the reference model
        for (int n = 0; n < 4; n++) begin
            rpt = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rexp = ref_encrypt(rpt, rkey);
            accept(rpt, rkey);
            wait_out("rand", rexp);
            release_out(int'($urandom_range(0, 3)), rexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
